multi_cycle_control_unit: RTL

- Finite-state controller that sequences a multi-cycle version of the team's MIPS-subset datapath (PC, instruction register, register file, ALU, data memory, sign/zero extender).
- Each instruction is split into IF/ID/EXE/MEM/WB cycles. The block emits per-cycle write strobes plus opcode-decoded datapath selects.
- Successor to the single-cycle control unit; sits between the instruction register (Opcode) and the datapath.

---
 rtl/multi_cycle_control_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM: IF/ID/EXE/MEM/WB strobes plus opcode-decoded selects.
// Optional `MCU_RETIRE_CNT_EN adds a 32-bit RetireCount of PCWre pulses.
module multi_cycle_control_unit #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter logic [1:0] JAL_DST = 2'b00
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       Sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] State,
  output logic       Halted
`ifdef MCU_RETIRE_CNT_EN
  ,
  output logic [31:0] RetireCount
`endif
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t state_q, state_d;
  logic is_alu, is_lw, is_sw, is_beq, is_bne, is_bltz, is_j, is_jal, is_jr;
  logic taken;
  logic pcw, irw, ins, rgw, mrd, mwr, hlt;
  logic [1:0] pcs;

  always_comb begin
    ALUOp = '0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ExtSel = 1'b0;
    RegDst = '0; DBDataSrc = 1'b0; WrRegDSrc = 1'b0;
    is_alu = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
    is_bltz = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    case (Opcode)
      6'b000000: begin is_alu = 1'b1; ALUOp = 3'b000; RegDst = 2'b10; WrRegDSrc = 1'b1; end
      6'b000001: begin is_alu = 1'b1; ALUOp = 3'b001; RegDst = 2'b10; WrRegDSrc = 1'b1; end
      6'b000010: begin is_alu = 1'b1; ALUOp = 3'b000; ALUSrcB = 1'b1; ExtSel = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; end
      6'b010000: begin is_alu = 1'b1; ALUOp = 3'b100; RegDst = 2'b10; WrRegDSrc = 1'b1; end
      6'b010001: begin is_alu = 1'b1; ALUOp = 3'b100; ALUSrcB = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; end
      6'b010010: begin is_alu = 1'b1; ALUOp = 3'b011; ALUSrcB = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; end
      6'b010011: begin is_alu = 1'b1; ALUOp = 3'b111; ALUSrcB = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; end
      6'b011000: begin is_alu = 1'b1; ALUOp = 3'b010; ALUSrcA = 1'b1; RegDst = 2'b10; WrRegDSrc = 1'b1; end
      6'b100110: begin is_alu = 1'b1; ALUOp = 3'b110; ALUSrcB = 1'b1; ExtSel = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; end
      6'b110000: begin is_sw = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; end
      6'b110001: begin is_lw = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; RegDst = 2'b01; DBDataSrc = 1'b1; WrRegDSrc = 1'b1; end
      6'b110100: begin is_beq = 1'b1; ALUOp = 3'b001; ExtSel = 1'b1; end
      6'b110101: begin is_bne = 1'b1; ALUOp = 3'b001; ExtSel = 1'b1; end
      6'b110110: begin is_bltz = 1'b1; ALUOp = 3'b110; ExtSel = 1'b1; end
      6'b111000: is_j = 1'b1;
      6'b111001: is_jr = 1'b1;
      6'b111010: begin is_j = 1'b1; is_jal = 1'b1; RegDst = JAL_DST; end
      default: ;
    endcase
  end

  assign taken = (is_beq & Zero) | (is_bne & ~Zero) | (is_bltz & Sign);

  always_comb begin
    state_d = state_q;
    pcw = 1'b0; irw = 1'b0; ins = 1'b0; rgw = 1'b0;
    mrd = 1'b0; mwr = 1'b0; hlt = 1'b0; pcs = 2'b00;
    case (state_q)
      S_IF: begin ins = 1'b1; irw = 1'b1; state_d = S_ID; end
      S_ID: begin
        // Halt is tested first so it wins even if HALT_OP is overridden onto a defined opcode.
        if (Opcode == HALT_OP) begin
          hlt = 1'b1;
        end else if (is_j) begin
          pcw = 1'b1; pcs = 2'b11; rgw = is_jal; state_d = S_IF;
        end else if (is_jr) begin
          pcw = 1'b1; pcs = 2'b10; state_d = S_IF;
        end else if (is_beq | is_bne | is_bltz) begin
          state_d = S_EXE_BR;
        end else if (is_lw | is_sw) begin
          state_d = S_EXE_LS;
        end else if (is_alu) begin
          state_d = S_EXE_AL;
        end else begin
          pcw = 1'b1; state_d = S_IF;
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  begin rgw = 1'b1; pcw = 1'b1; state_d = S_IF; end
      S_EXE_BR: begin pcw = 1'b1; pcs = taken ? 2'b01 : 2'b00; state_d = S_IF; end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (is_lw) begin
          mrd = 1'b1; state_d = S_WB_LD;
        end else begin
          mwr = is_sw; pcw = 1'b1; state_d = S_IF;
        end
      end
      S_WB_LD: begin mrd = 1'b1; rgw = 1'b1; pcw = 1'b1; state_d = S_IF; end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Strobes are gated by Reset so they fall in the same cycle reset is asserted.
  assign PCWre    = Reset & pcw;
  assign IRWre    = Reset & irw;
  assign InsMemRW = Reset & ins;
  assign RegWre   = Reset & rgw;
  assign mRD      = Reset & mrd;
  assign mWR      = Reset & mwr;
  assign Halted   = Reset & hlt;
  assign PCSrc    = Reset ? pcs : 2'b00;
  assign State    = state_q;

`ifdef MCU_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb cnt_d = PCWre ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign RetireCount = cnt_q;
`endif

endmodule
